// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues req/ack transactions to a variable-latency
// data memory, stalls EX/MEM while busy, flags misaligned/illegal/timed-out accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_reg_write_i,
  input  logic        mem_mem_to_reg_i,
  input  logic        mem_mem_read_i,
  input  logic        mem_mem_write_i,
  input  logic [31:0] mem_alu_out_i,
  input  logic [31:0] mem_rt_data_i,
  input  logic [4:0]  mem_rd_reg_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_c_o,
  output logic        mem_fault_o,
  output logic        wb_reg_write_o,
  output logic        wb_mem_to_reg_o,
  output logic [4:0]  wb_rd_reg_o,
  output logic [31:0] wb_alu_out_o,
  output logic [31:0] wb_read_data_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          fault_q, fault_d;
  logic          wb_rw_q, wb_rw_d;
  logic          wb_m2r_q, wb_m2r_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_alu_q, wb_alu_d;
  logic [DW-1:0] wb_rdata_q, wb_rdata_d;
  logic          stall_c;
  logic          access_c;
  logic          bad_access_c;
  logic          timeout_c;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

  // Next-state and stall decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fault_d      = 1'b0;
    wb_rw_d      = wb_rw_q;
    wb_m2r_d     = wb_m2r_q;
    wb_rd_d      = wb_rd_q;
    wb_alu_d     = wb_alu_q;
    wb_rdata_d   = wb_rdata_q;
    stall_c      = 1'b0;
    access_c     = mem_mem_read_i | mem_mem_write_i;
    bad_access_c = (mem_mem_read_i & mem_mem_write_i) | (mem_alu_out_i[1:0] != 2'b00);
    timeout_c    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (!access_c) begin
          wb_rw_d  = mem_reg_write_i;
          wb_m2r_d = mem_mem_to_reg_i;
          wb_rd_d  = mem_rd_reg_i;
          wb_alu_d = mem_alu_out_i;
        end else if (bad_access_c) begin
          fault_d = 1'b1;
          wb_rw_d = 1'b0;
        end else begin
          stall_c = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_mem_write_i;
          addr_d  = mem_alu_out_i;
          wdata_d = mem_rt_data_i;
          cnt_d   = '0;
          wb_rw_d = 1'b0;
        end
      end
      BUSY: begin
        // Ack takes priority over a coincident timeout
        if (dmem_ack_i) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          wb_rw_d  = mem_reg_write_i;
          wb_m2r_d = mem_mem_to_reg_i;
          wb_rd_d  = mem_rd_reg_i;
          wb_alu_d = mem_alu_out_i;
          if (!we_q) wb_rdata_d = dmem_rdata_i;
        end else if (timeout_c) begin
          state_d = IDLE;
          req_d   = 1'b0;
          fault_d = 1'b1;
          wb_rw_d = 1'b0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          wb_rw_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall_c_o   = rst_ni & stall_c;
  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_wdata_o    = wdata_q;
  assign mem_fault_o     = fault_q;
  assign wb_reg_write_o  = wb_rw_q;
  assign wb_mem_to_reg_o = wb_m2r_q;
  assign wb_rd_reg_o     = wb_rd_q;
  assign wb_alu_out_o    = wb_alu_q;
  assign wb_read_data_o  = wb_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized instructions
// checked against a transaction-level model of the MEM stage.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk_i, rst_ni;
  logic        mem_reg_write_i, mem_mem_to_reg_i, mem_mem_read_i, mem_mem_write_i;
  logic [31:0] mem_alu_out_i, mem_rt_data_i;
  logic [4:0]  mem_rd_reg_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        mem_stall_c_o, mem_fault_o;
  logic        wb_reg_write_o, wb_mem_to_reg_o;
  logic [4:0]  wb_rd_reg_o;
  logic [31:0] wb_alu_out_o, wb_read_data_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model of the architecturally visible WB state
  logic        m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_reg_write_i(mem_reg_write_i), .mem_mem_to_reg_i(mem_mem_to_reg_i),
    .mem_mem_read_i(mem_mem_read_i), .mem_mem_write_i(mem_mem_write_i),
    .mem_alu_out_i(mem_alu_out_i), .mem_rt_data_i(mem_rt_data_i), .mem_rd_reg_i(mem_rd_reg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_stall_c_o(mem_stall_c_o), .mem_fault_o(mem_fault_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_rd_reg_o(wb_rd_reg_o), .wb_alu_out_o(wb_alu_out_o), .wb_read_data_o(wb_read_data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic clear_inputs;
    mem_reg_write_i = 0; mem_mem_to_reg_i = 0; mem_mem_read_i = 0; mem_mem_write_i = 0;
    mem_alu_out_i = 0; mem_rt_data_i = 0; mem_rd_reg_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  // Present one instruction at the current negedge, hold it until the stage advances, then
  // check the outcome. lat = BUSY cycle (1-based) carrying Ack; lat=0 gives a stray Ack in
  // the IDLE cycle only. Returns at the negedge after the advancing edge.
  task automatic do_instr(input string nm, input logic rw, input logic m2r, input logic rd,
                          input logic wr, input logic [31:0] alu, input logic [31:0] wdata,
                          input logic [4:0] rdreg, input int lat, input logic [31:0] rdata);
    int stalls = 0, reqs = 0, cyc = 0, exp_st, exp_rq;
    bit done = 0, attr_ok = 1, is_acc, is_bad;
    logic exp_fault;
    mem_reg_write_i = rw; mem_mem_to_reg_i = m2r; mem_mem_read_i = rd; mem_mem_write_i = wr;
    mem_alu_out_i = alu; mem_rt_data_i = wdata; mem_rd_reg_i = rdreg;
    while (!done && cyc < 300) begin
      dmem_ack_i   = (cyc == lat);
      dmem_rdata_i = (cyc == lat) ? rdata : $urandom;
      #1;
      if (mem_stall_c_o) stalls++;
      if (dmem_req_o) begin
        reqs++;
        if (dmem_we_o !== wr || dmem_addr_o !== alu || dmem_wdata_o !== wdata) attr_ok = 0;
      end
      if (!mem_stall_c_o) done = 1;
      @(negedge clk_i);
      cyc++;
    end
    dmem_ack_i = 0;

    is_acc = rd | wr;
    is_bad = is_acc && ((rd && wr) || alu[1:0] != 2'b00);
    if (!is_acc) begin
      exp_st = 0; exp_rq = 0; exp_fault = 0;
      m_rw = rw; m_m2r = m2r; m_rd = rdreg; m_alu = alu;
    end else if (is_bad) begin
      exp_st = 0; exp_rq = 0; exp_fault = 1; m_rw = 0;
    end else if (lat >= 1 && lat <= TO) begin
      exp_st = lat; exp_rq = lat; exp_fault = 0;
      m_rw = rw; m_m2r = m2r; m_rd = rdreg; m_alu = alu;
      if (rd) m_rdata = rdata;
    end else begin
      exp_st = TO; exp_rq = TO; exp_fault = 1; m_rw = 0;
    end

    total_cnt++;
    if (!done) $display("FAIL %s stall-bound: stall never released within 300 cycles", nm);
    else pass_cnt++;
    total_cnt++;
    if (stalls !== exp_st) $display("FAIL %s stall-cycles: got %0d exp %0d", nm, stalls, exp_st);
    else pass_cnt++;
    total_cnt++;
    if (reqs !== exp_rq) $display("FAIL %s req-cycles: got %0d exp %0d", nm, reqs, exp_rq);
    else pass_cnt++;
    total_cnt++;
    if (!attr_ok) $display("FAIL %s req-attrs: we/addr/wdata got %b/%h/%h exp %b/%h/%h", nm,
                           dmem_we_o, dmem_addr_o, dmem_wdata_o, wr, alu, wdata);
    else pass_cnt++;
    total_cnt++;
    if (dmem_req_o !== 1'b0) $display("FAIL %s req-after: got %b exp 0", nm, dmem_req_o);
    else pass_cnt++;
    total_cnt++;
    if (mem_fault_o !== exp_fault) $display("FAIL %s fault: got %b exp %b", nm, mem_fault_o, exp_fault);
    else pass_cnt++;
    total_cnt++;
    if (wb_reg_write_o !== m_rw || wb_mem_to_reg_o !== m_m2r || wb_rd_reg_o !== m_rd)
      $display("FAIL %s wb-ctrl: got rw=%b m2r=%b rd=%0d exp rw=%b m2r=%b rd=%0d", nm,
               wb_reg_write_o, wb_mem_to_reg_o, wb_rd_reg_o, m_rw, m_m2r, m_rd);
    else pass_cnt++;
    total_cnt++;
    if (wb_alu_out_o !== m_alu) $display("FAIL %s wb-alu: got %h exp %h", nm, wb_alu_out_o, m_alu);
    else pass_cnt++;
    total_cnt++;
    if (wb_read_data_o !== m_rdata)
      $display("FAIL %s wb-rdata: got %h exp %h", nm, wb_read_data_o, m_rdata);
    else pass_cnt++;
  endtask

  task automatic check_all_zero(input string nm);
    total_cnt++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, mem_stall_c_o, mem_fault_o,
         wb_reg_write_o, wb_mem_to_reg_o, wb_rd_reg_o, wb_alu_out_o, wb_read_data_o} !== '0)
      $display("FAIL %s outputs-zero: req=%b stall=%b fault=%b wb_rw=%b alu=%h rdata=%h exp all 0",
               nm, dmem_req_o, mem_stall_c_o, mem_fault_o, wb_reg_write_o, wb_alu_out_o,
               wb_read_data_o);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_ni = 0;
    mem_mem_read_i = 1; mem_alu_out_i = 32'h0000_0040;
    m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
    repeat (2) @(negedge clk_i);
    #1 check_all_zero("reset");
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1;
  endtask

  task automatic test_alu;
    do_instr("alu", 1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 9, 32'h0);
  endtask

  task automatic test_load;
    do_instr("load", 1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_store;
    do_instr("store", 0, 0, 0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0, 1, 32'hCAFE_F00D);
  endtask

  task automatic test_fault;
    do_instr("misaligned", 1, 1, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h1111_1111);
    do_instr("fault-clear", 1, 0, 0, 0, 32'h0000_0033, 32'h0, 5'd3, 9, 32'h0);
    do_instr("rd-and-wr", 1, 1, 1, 1, 32'h0000_0108, 32'h5, 5'd4, 1, 32'h2222_2222);
  endtask

  task automatic test_timeout;
    do_instr("timeout", 1, 1, 1, 0, 32'h0000_0400, 32'h0, 5'd11, 0, 32'hBAD0_BAD0);
    do_instr("late-ack", 0, 0, 0, 0, 32'h0000_0404, 32'h0, 5'd12, 0, 32'hBAD1_BAD1);
    do_instr("ack-at-limit", 1, 1, 1, 0, 32'h0000_0408, 32'h0, 5'd13, TO, 32'h0BAD_F00D);
  endtask

  task automatic test_back_to_back;
    do_instr("b2b-load1", 1, 1, 1, 0, 32'h0000_0010, 32'h0, 5'd1, 1, 32'hA5A5_0001);
    do_instr("b2b-store", 0, 0, 0, 1, 32'h0000_0014, 32'h7777_8888, 5'd0, 2, 32'h0);
    do_instr("b2b-load2", 1, 1, 1, 0, 32'h0000_0018, 32'h0, 5'd2, 1, 32'hA5A5_0002);
  endtask

  task automatic test_reset_mid_access;
    mem_reg_write_i = 1; mem_mem_to_reg_i = 1; mem_mem_read_i = 1; mem_mem_write_i = 0;
    mem_alu_out_i = 32'h0000_0300; mem_rt_data_i = 0; mem_rd_reg_i = 5'd6; dmem_ack_i = 0;
    repeat (2) @(negedge clk_i);
    #1;
    total_cnt++;
    if (dmem_req_o !== 1'b1) $display("FAIL rst-mid req-before: got %b exp 1", dmem_req_o);
    else pass_cnt++;
    #1 rst_ni = 0;
    #1 check_all_zero("rst-mid");
    m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1;
    do_instr("post-rst-load", 1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd6, 2, 32'h600D_0300);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      int kind = $urandom_range(0, 4);
      int lat = $urandom_range(0, TO + 2);
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      logic [31:0] wd = $urandom;
      logic [31:0] rdt = $urandom;
      logic [4:0] rdr = 5'($urandom_range(0, 31));
      logic rw = 1'($urandom_range(0, 1));
      logic m2r = 1'($urandom_range(0, 1));
      case (kind)
        0: do_instr("rnd-alu", rw, m2r, 0, 0, $urandom, wd, rdr, lat, rdt);
        1: do_instr("rnd-load", rw, m2r, 1, 0, a, wd, rdr, lat, rdt);
        2: do_instr("rnd-store", rw, m2r, 0, 1, a, wd, rdr, lat, rdt);
        3: do_instr("rnd-misalign", rw, m2r, 1, 0, a | 32'($urandom_range(1, 3)), wd, rdr, lat, rdt);
        default: do_instr("rnd-both", rw, m2r, 1, 1, a, wd, rdr, lat, rdt);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_fault();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random(60);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access controller on the consumer side of the EX/MEM pipeline register. It turns the latched MEM_* control and data into a request/acknowledge transaction with a variable-latency data memory, and stalls the EX/MEM register while an access is outstanding. It flags misaligned and timed-out accesses, and registers the stage results into the MEM/WB boundary.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without Dmem_Ack before an access is aborted (1..255).
- Clock  in  1  processor clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- MEM_RegWrite  in  1  WB control from EX/MEM.
- MEM_MemtoReg  in  1  WB control from EX/MEM.
- MEM_MemRead  in  1  load request.
- MEM_MemWrite  in  1  store request.
- MEM_ALUOut  in  32  byte address for loads/stores; result for other instructions.
- MEM_RtData  in  32  store data.
- MEM_RdReg  in  5  destination register.
- Dmem_Req  out  1  request valid; held until Ack or abort.
- Dmem_We  out  1  1 = write, 0 = read; valid while Dmem_Req.
- Dmem_Addr  out  32  word address (byte address, [1:0] = 0); valid while Dmem_Req.
- Dmem_WData  out  32  store data; valid while Dmem_Req.
- Dmem_Ack  in  1  single-cycle completion strobe from memory.
- Dmem_RData  in  32  read data, valid in the Ack cycle.
- Mem_Stall  out  1  combinational; drives EXMEMWrite low and stalls upstream stages.
- Mem_Fault  out  1  registered one-cycle pulse: misaligned, illegal, or timed-out access.
- WB_RegWrite, WB_MemtoReg  out  1 each  registered WB control.
- WB_RdReg  out  5  registered destination.
- WB_ALUOut  out  32  registered ALU result.
- WB_ReadData  out  32  registered load data.

## Operation
- State machine has two states, IDLE and BUSY. Access = MEM_MemRead | MEM_MemWrite.
- IDLE, no access:
  - Mem_Stall = 0.
  - WB registers capture MEM_RegWrite/MemtoReg/RdReg/ALUOut.
  - WB_ReadData holds its value.
- IDLE, both MemRead and MemWrite = 1, or MEM_ALUOut[1:0] != 0:
  - The access is a fault. No request is issued and Mem_Stall = 0.
  - At the next edge, Mem_Fault = 1 and WB_RegWrite = 0. The instruction is squashed and the pipeline advances.
- IDLE, valid access:
  - Mem_Stall = 1.
  - At the edge: go to BUSY, Dmem_Req <= 1, Dmem_We <= MEM_MemWrite, Dmem_Addr <= MEM_ALUOut, Dmem_WData <= MEM_RtData, timeout counter <= 0, WB_RegWrite <= 0 (bubble).
- BUSY, Dmem_Ack = 0:
  - Mem_Stall = 1 and the counter increments.
  - WB_RegWrite <= 0 on each edge.
  - Request outputs are stable.
- BUSY, Dmem_Ack = 1:
  - Mem_Stall = 0.
  - At the edge: Dmem_Req <= 0, state <= IDLE, WB registers capture MEM_* fields, WB_ReadData <= Dmem_RData (loads only; stores leave it unchanged).
  - EX/MEM advances on the same edge.
- BUSY, counter == TIMEOUT_CYCLES - 1 with no Ack:
  - Mem_Stall = 0.
  - At the edge: Dmem_Req <= 0, state <= IDLE, Mem_Fault <= 1, WB_RegWrite <= 0.
- Ack and timeout in the same cycle: Ack wins (normal completion, no fault).
- Dmem_Ack while IDLE is ignored; no output changes.
- The counter is 8 bits wide and never wraps, because the timeout forces exit first.

## Timing
- Reset value of every output and register is 0, including the state (IDLE) and the counter. Reset asserted mid-access drops Dmem_Req asynchronously, and the pending access is abandoned with no fault.
- Non-memory instruction: WB outputs are valid 1 cycle after it is present on MEM_*, with no stall.
- Memory access with Ack on the k-th BUSY cycle (k >= 1):
  - Mem_Stall is high for k cycles (the IDLE cycle plus k-1 BUSY cycles).
  - The instruction occupies EX/MEM for k+1 cycles.
  - WB outputs update at the edge ending the Ack cycle.
- Minimum access: Ack in the first BUSY cycle gives 1 stall cycle, and Dmem_Req is high for exactly 1 cycle.
- Back-to-back accesses: the next access can begin in the IDLE cycle right after completion. Dmem_Req is low for at least 1 cycle between requests.
- Mem_Fault is high for exactly one cycle per faulting instruction.

## Test plan
- ALU instruction (RegWrite=1, RdReg=5, ALUOut=0x0000_0010, no access) -> next cycle WB_RegWrite=1, WB_RdReg=5, WB_ALUOut=0x10; Mem_Stall never asserted.
- Load at 0x100, memory acks 3 cycles after Req rises with RData=0xDEAD_BEEF -> Dmem_Req high 3 cycles, Dmem_We=0, Dmem_Addr=0x100, Mem_Stall high 3 cycles, then WB_ReadData=0xDEAD_BEEF, WB_MemtoReg=1.
- Store at 0x204 with RtData=0x1234_5678, Ack in the first BUSY cycle -> Dmem_We=1, Dmem_WData=0x1234_5678, exactly 1 stall cycle, WB_ReadData unchanged.
- Load at 0x102 (misaligned) -> Dmem_Req stays 0, Mem_Stall stays 0, Mem_Fault pulses 1 cycle, WB_RegWrite=0.
- TIMEOUT_CYCLES=4, load with Ack never asserted -> Dmem_Req high 4 cycles, then Mem_Fault pulse, WB_RegWrite=0, state IDLE; a late Ack is ignored.
- Reset taken low on the second BUSY cycle of a load -> Dmem_Req falls without waiting for a clock edge, all outputs 0; after release, a new load completes normally.
